// File: rtl/bitwise_logic_if.sv
// Operand/result handshake bundle for bitwise_logic_pipe.
// The slave modport is the pipeline side; the master modport is the producer/consumer side.
interface bitwise_logic_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             all_zero;
  logic             all_ones;
  logic             parity;
  logic [CW-1:0]    popcount;

  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, result, all_zero, all_ones, parity, popcount
  );

  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, result, all_zero, all_ones, parity, popcount
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined selectable bitwise unit with optional accumulate chaining,
// result reduction flags and population count; valid/ready on both sides.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst_n,
  bitwise_logic_if.slave bus
);

  function automatic logic [WIDTH-1:0] bit_op(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [2:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x & ~y;
      default: r = ~x;
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] pop_cnt(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  logic             adv1, adv2, xfer_in;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opb_p0, res_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] res_p2;
  logic             az_p2, ao_p2, par_p2;
  logic [CW-1:0]    pop_p2;

  assign adv2    = ~vld_p2 | bus.out_ready;
  assign adv1    = ~vld_p1 | adv2;
  assign xfer_in = bus.in_valid & adv1;

  // ---- stage 0: operand select and function evaluation ----
  assign opb_p0 = bus.acc_en ? acc : bus.b;
  assign res_p0 = bit_op(bus.a, opb_p0, bus.op);

  // Updating acc at capture time lets back-to-back accumulate beats chain without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (bus.acc_clr) begin
      acc <= '0;
    end else if (xfer_in && bus.acc_en) begin
      acc <= res_p0;
    end
  end

  // ---- stage 1: registered function result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (adv1) begin
      vld_p1 <= xfer_in;
      if (xfer_in) begin
        res_p1 <= res_p0;
      end
    end
  end

  // ---- stage 2: registered result with reduction flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      az_p2  <= 1'b1;
      ao_p2  <= 1'b0;
      par_p2 <= 1'b0;
      pop_p2 <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2 <= res_p1;
        az_p2  <= ~|res_p1;
        ao_p2  <= &res_p1;
        par_p2 <= ^res_p1;
        pop_p2 <= pop_cnt(res_p1);
      end
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = vld_p2;
  assign bus.result    = res_p2;
  assign bus.all_zero  = az_p2;
  assign bus.all_ones  = ao_p2;
  assign bus.parity    = par_p2;
  assign bus.popcount  = pop_p2;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: directed WIDTH=8 scenarios plus
// random WIDTH=1 and WIDTH=13 instances checked against a truth-table model.
module tb_bitwise_logic_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitwise_logic_if #(.WIDTH(8))  i8  ();
  bitwise_logic_if #(.WIDTH(1))  i1  ();
  bitwise_logic_if #(.WIDTH(13)) i13 ();

  bitwise_logic_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  bitwise_logic_pipe #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(i1));
  bitwise_logic_pipe #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(i13));

  typedef struct {
    logic [7:0] r;
    int         t;
    int         lat;
  } exp8_t;

  exp8_t       q8[$];
  logic        q1[$];
  logic [12:0] q13[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] ref_op(input logic [12:0] x, input logic [12:0] y,
                                         input logic [2:0] o);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return ~x;
    endcase
  endfunction

  // Drive one WIDTH=8 beat; the expected result is queued at the accepting edge.
  task automatic send8(input logic [7:0] ta, input logic [7:0] tbv, input logic [2:0] top,
                       input logic ten, input logic tclr, input logic [7:0] er, input int lat);
    bit ok;
    int t;
    ok = 1'b0;
    t  = 0;
    @(negedge clk);
    i8.in_valid = 1'b1;
    i8.a        = ta;
    i8.b        = tbv;
    i8.op       = top;
    i8.acc_en   = ten;
    i8.acc_clr  = tclr;
    for (int k = 0; k < 50 && !ok; k++) begin
      #4;
      if (i8.in_ready) begin
        ok = 1'b1;
        t  = cyc;
      end
      @(posedge clk);
    end
    if (ok) q8.push_back('{er, t, lat});
    else chk("send8_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle8();
    @(negedge clk);
    i8.in_valid = 1'b0;
    i8.acc_en   = 1'b0;
    i8.acc_clr  = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((q8.size() + q1.size() + q13.size()) != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(q8.size() + q1.size() + q13.size()), 32'd0);
  endtask

  task automatic run_rand(input int n);
    logic [12:0] ra, rb, rr;
    logic [2:0]  ro, o1;
    logic        a1, b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ra = 13'($urandom);
      rb = 13'($urandom);
      ro = 3'($urandom_range(0, 7));
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      o1 = 3'($urandom_range(0, 7));
      i13.in_valid = 1'b1; i13.a = ra; i13.b = rb; i13.op = ro;
      i1.in_valid  = 1'b1; i1.a  = a1; i1.b  = b1; i1.op  = o1;
      #4;
      if (i13.in_ready) q13.push_back(ref_op(ra, rb, ro));
      else chk("w13_in_ready", 32'(i13.in_ready), 32'd1);
      rr = ref_op({12'b0, a1}, {12'b0, b1}, o1);
      if (i1.in_ready) q1.push_back(rr[0]);
      else chk("w1_in_ready", 32'(i1.in_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    i13.in_valid = 1'b0;
    i1.in_valid  = 1'b0;
  endtask

  // ---- WIDTH=8 monitor: pops on every output transfer, checks hold under stall ----
  exp8_t       e8;
  bit          held = 1'b0;
  logic [31:0] held_val;

  always @(negedge clk) begin
    if (rst_n && i8.out_valid) begin
      if (held)
        chk("stall_hold", 32'({i8.result, i8.all_zero, i8.all_ones, i8.parity, i8.popcount}),
            held_val);
      if (i8.out_ready) begin
        held = 1'b0;
        if (q8.size() == 0) begin
          chk("unexpected_out8", 32'd1, 32'd0);
        end else begin
          e8 = q8.pop_front();
          chk("result8", 32'(i8.result), 32'(e8.r));
          chk("popcount8", 32'(i8.popcount), 32'($countones(e8.r)));
          chk("all_zero8", 32'(i8.all_zero), 32'(e8.r == 8'h00));
          chk("all_ones8", 32'(i8.all_ones), 32'(e8.r == 8'hFF));
          chk("parity8", 32'(i8.parity), 32'(^e8.r));
          if (e8.lat > 0) chk("latency8", 32'(cyc - e8.t), 32'(e8.lat));
        end
      end else begin
        held     = 1'b1;
        held_val = 32'({i8.result, i8.all_zero, i8.all_ones, i8.parity, i8.popcount});
      end
    end else begin
      held = 1'b0;
    end
  end

  logic [12:0] e13;
  logic        e1;

  always @(negedge clk) begin
    if (rst_n && i13.out_valid) begin
      if (q13.size() == 0) begin
        chk("unexpected_out13", 32'd1, 32'd0);
      end else begin
        e13 = q13.pop_front();
        chk("result13", 32'(i13.result), 32'(e13));
        chk("popcount13", 32'(i13.popcount), 32'($countones(e13)));
        chk("flags13", 32'({i13.all_zero, i13.all_ones, i13.parity}),
            32'({e13 == 13'h0, e13 == 13'h1FFF, ^e13}));
      end
    end
    if (rst_n && i1.out_valid) begin
      if (q1.size() == 0) begin
        chk("unexpected_out1", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("result1", 32'(i1.result), 32'(e1));
        chk("popcount1", 32'(i1.popcount), 32'(e1));
        chk("flags1", 32'({i1.all_zero, i1.all_ones, i1.parity}), 32'({~e1, e1, e1}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [7:0] sweep[8];
  logic [7:0] acc_a[4];
  logic [7:0] acc_r[4];
  bit         saw_stall;

  initial begin
    sweep = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hC0, 8'h0F};
    acc_a = '{8'h01, 8'h02, 8'h04, 8'h08};
    acc_r = '{8'h01, 8'h03, 8'h07, 8'h0F};
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.op = '0;
    i8.acc_en = 1'b0; i8.acc_clr = 1'b0; i8.out_ready = 1'b1;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.op = '0;
    i1.acc_en = 1'b0; i1.acc_clr = 1'b0; i1.out_ready = 1'b1;
    i13.in_valid = 1'b0; i13.a = '0; i13.b = '0; i13.op = '0;
    i13.acc_en = 1'b0; i13.acc_clr = 1'b0; i13.out_ready = 1'b1;
    rst_n = 1'b0;
    #23 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(i8.out_valid), 32'd0);
    chk("rst_result", 32'(i8.result), 32'd0);
    chk("rst_all_zero", 32'(i8.all_zero), 32'd1);
    chk("rst_all_ones", 32'(i8.all_ones), 32'd0);
    chk("rst_parity", 32'(i8.parity), 32'd0);
    chk("rst_popcount", 32'(i8.popcount), 32'd0);
    chk("rst_in_ready", 32'(i8.in_ready), 32'd1);

    for (int k = 0; k < 8; k++) send8(8'hF0, 8'h3C, 3'(k), 1'b0, 1'b0, sweep[k], 2);
    send8(8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 2);
    send8(8'hFF, 8'h00, 3'd1, 1'b0, 1'b0, 8'hFF, 2);
    idle8();
    drain("drain_basic");

    // Clear pulse, then invalid-cycle garbage that must not touch acc.
    @(negedge clk);
    i8.acc_clr = 1'b1;
    @(negedge clk);
    i8.acc_clr = 1'b0; i8.acc_en = 1'b1; i8.a = 8'hAA; i8.op = 3'd1;
    for (int k = 0; k < 4; k++) send8(acc_a[k], 8'hFF, 3'd1, 1'b1, 1'b0, acc_r[k], 2);
    send8(8'h10, 8'hFF, 3'd1, 1'b1, 1'b1, 8'h1F, 2);
    send8(8'h20, 8'hFF, 3'd1, 1'b1, 1'b0, 8'h20, 2);
    idle8();
    drain("drain_acc");

    saw_stall = 1'b0;
    fork
      begin
        for (int k = 1; k <= 5; k++)
          send8(8'(8'h11 * k), 8'hFF, 3'd0, 1'b0, 1'b0, 8'(8'h11 * k), 0);
        idle8();
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (i8.out_valid) break;
        end
        @(posedge clk);
        #1 i8.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!i8.in_ready) saw_stall = 1'b1;
        end
        @(posedge clk);
        #1 i8.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    chk("in_ready_drop", 32'(saw_stall), 32'd1);

    send8(8'h0F, 8'h00, 3'd4, 1'b1, 1'b0, 8'h2F, 0);
    send8(8'hF0, 8'h00, 3'd4, 1'b1, 1'b0, 8'hDF, 0);
    #1 chk("pre_rst_out_valid", 32'(i8.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    i8.in_valid = 1'b0;
    i8.acc_en = 1'b0;
    q8.delete();
    #1;
    chk("midrst_out_valid", 32'(i8.out_valid), 32'd0);
    chk("midrst_acc", 32'(dut8.acc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(i8.in_ready), 32'd1);
    send8(8'h3C, 8'h0F, 3'd4, 1'b0, 1'b0, 8'h33, 2);
    idle8();
    chk("post_rst_early_valid", 32'(i8.out_valid), 32'd0);
    drain("drain_post_rst");

    run_rand(40);
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
Name: bitwise_logic_pipe

Overview:
- Parametrised, pipelined successor to the single-op bitwise gate blocks.
- One instance selects among eight two-operand bitwise functions per transaction.
- Optional accumulate mode chains results through an internal register.
- Stage 2 produces reduction flags and a population count; valid/ready handshake on input and output with full backpressure.
- Sits between operand-fetch logic and any consumer needing masked or flagged bit-vectors.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CW, $clog2(WIDTH+1), popcount width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored when acc_en=1).
- op  in  3  function select.
- acc_en  in  1  use accumulator as operand B and update it.
- acc_clr  in  1  synchronous clear of accumulator.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  function result.
- all_zero  out  1  result == 0.
- all_ones  out  1  result == all ones.
- parity  out  1  XOR-reduction of result.
- popcount  out  CW  number of set bits in result.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- op encoding (B' = acc_en ? acc : b):
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 A&~B'.
  - 7 ~A (B' ignored).
- Pipeline, two registered stages, each with its own valid bit (v1, v2):
  - S1 registers res1 = f(a, B', op).
  - S2 registers result and all flags, computed from res1.
- Latency: a beat accepted at edge N appears on outputs after edge N+1, i.e. out_valid is high in cycle N+2 when there is no stall.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - adv2 = ~v2 | out_ready.
  - adv1 = ~v1 | adv2.
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
  - Throughput is one beat per cycle while out_ready=1.
  - Under stall, S2 contents and all outputs hold stable while out_valid=1.
  - S1 holds when ~adv2.
  - On S2 advance with ~v1, v2 clears.
- Accumulator (acc, WIDTH bits):
  - acc updates to res1's new value only on an input transfer with acc_en=1.
  - acc_clr=1 sets acc=0 next edge.
  - acc_clr has priority over a simultaneous acc_en update.
  - A beat accepted in the same cycle as acc_clr uses the old acc value.
  - Back-to-back acc_en beats see each prior result with no bubble, since acc is updated at S1 capture.
- Flags are recomputed from the S2 result only.
  - WIDTH=1: all_zero = ~result, all_ones = result, popcount = result.
- Reset values: v1=v2=0, acc=0, res1/result=0.
  - Outputs after reset: out_valid=0, result=0, all_zero=1, all_ones=0, parity=0, popcount=0.
  - in_ready=1 once out of reset.
- Reset mid-operation clears all in-flight beats immediately, with no output transfer.
- Data inputs when in_valid=0 are don't-care and must not affect acc or stages.

Test Plan:
- WIDTH=8, out_ready=1, a=8'hF0, b=8'h3C, op 0..7 on consecutive cycles -> results in order, latency 2, no bubbles: 30,FC,CF,03,CC,33,C0,0F.
- a=8'hFF, b=8'h00, op=0 -> result=00, all_zero=1, popcount=0, parity=0. Then op=1 -> result=FF, all_ones=1, popcount=8.
- Accumulate: acc_clr pulse, then acc_en=1, op=1 (OR), a=01,02,04,08 back-to-back -> results 01,03,07,0F. A fifth beat with acc_clr asserted in the same cycle and a=10 -> result 1F, and the following beat with a=20 -> 20.
- Backpressure: stream 5 beats, hold out_ready=0 for 4 cycles after the first output -> in_ready drops once both stages are full, result and flags stay stable, no beat is lost or duplicated, and order is preserved after release.
- Assert rst_n=0 asynchronously mid-stream with 2 beats in flight -> out_valid=0 immediately and acc=0. After release, the first new beat emerges 2 cycles after acceptance.
- WIDTH=1 and WIDTH=13 builds: random op/a/b checked against a reference model, with popcount width 1 and 4 respectively.
